// File: rtl/fft_vis_pkg.sv
// fft_vis_pkg: shared bin geometry, reader FSM states and signed-sample magnitude helper
package fft_vis_pkg;
    localparam int NUM_BINS = 16;
    localparam int BIN_W = 32;
    localparam int SAMPLE_W = 16;
    localparam int MAG_W = 17;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FLAG} reader_state_t;
    function automatic logic [MAG_W-1:0] abs_s16(input logic signed [SAMPLE_W-1:0] x);
        logic signed [MAG_W-1:0] e;
        e = MAG_W'(x);
        return x[SAMPLE_W-1] ? MAG_W'(-e) : MAG_W'(e);
    endfunction
endpackage

// File: rtl/fft_bar_reader_bin_magnitude.sv
// bin_magnitude: |re|+|im| of one packed bin (bin[31:16] re, bin[15:0] im) -> 17-bit mag
module bin_magnitude
    import fft_vis_pkg::*;
(
    input  logic [BIN_W-1:0] bin,
    output logic [MAG_W-1:0] mag
);
    assign mag = abs_s16(bin[BIN_W-1:SAMPLE_W]) + abs_s16(bin[SAMPLE_W-1:0]);
endmodule

// File: rtl/fft_bar_reader.sv
// fft_bar_reader: captures a 16-bin FFT frame on done, streams per-bin magnitudes (mag_*), peak-holds bar levels read via rd_addr/rd_level, flags frame_valid, counts skipped frames
module fft_bar_reader
    import fft_vis_pkg::*;
#(
    parameter int LEVEL_W = 8,
    parameter int SHIFT = 8,
    parameter int DECAY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               done,
    input  logic [BIN_W-1:0]   f0,
    input  logic [BIN_W-1:0]   f1,
    input  logic [BIN_W-1:0]   f2,
    input  logic [BIN_W-1:0]   f3,
    input  logic [BIN_W-1:0]   f4,
    input  logic [BIN_W-1:0]   f5,
    input  logic [BIN_W-1:0]   f6,
    input  logic [BIN_W-1:0]   f7,
    input  logic [BIN_W-1:0]   f8,
    input  logic [BIN_W-1:0]   f9,
    input  logic [BIN_W-1:0]   f10,
    input  logic [BIN_W-1:0]   f11,
    input  logic [BIN_W-1:0]   f12,
    input  logic [BIN_W-1:0]   f13,
    input  logic [BIN_W-1:0]   f14,
    input  logic [BIN_W-1:0]   f15,
    input  logic               clr_skip,
    input  logic [3:0]         rd_addr,
    output logic [LEVEL_W-1:0] rd_level,
    output logic               mag_valid,
    output logic [3:0]         mag_bin,
    output logic [MAG_W-1:0]   mag_data,
    output logic               busy,
    output logic               frame_valid,
    output logic [7:0]         skip_cnt
);
    localparam logic [MAG_W-1:0] LVL_MAX = MAG_W'((1 << LEVEL_W) - 1);
    reader_state_t state, state_n;
    logic [3:0] idx, idx_n;
    logic capture;
    logic [BIN_W-1:0] fin [NUM_BINS];
    logic [BIN_W-1:0] snap [NUM_BINS];
    logic [LEVEL_W-1:0] level [NUM_BINS];
    logic [MAG_W-1:0] mag, shifted;
    logic [LEVEL_W-1:0] cur, new_lvl, held;
    assign fin = '{f0, f1, f2, f3, f4, f5, f6, f7, f8, f9, f10, f11, f12, f13, f14, f15};
    bin_magnitude u_mag (.bin(snap[idx]), .mag(mag));
    assign busy = state != IDLE;
    assign frame_valid = state == FLAG;
    assign shifted = mag_data >> SHIFT;
    assign new_lvl = shifted > LVL_MAX ? LEVEL_W'(LVL_MAX) : LEVEL_W'(shifted);
    assign cur = level[mag_bin];
    assign held = cur >= LEVEL_W'(DECAY) ? cur - LEVEL_W'(DECAY) : '0;
    always_comb begin
        state_n = state;
        idx_n = idx;
        capture = 1'b0;
        case (state)
            IDLE: if (done && en) begin
                state_n = SCAN;
                idx_n = '0;
                capture = 1'b1;
            end
            SCAN: begin
                idx_n = idx + 4'd1;
                state_n = idx == 4'd15 ? DRAIN : SCAN;
            end
            DRAIN: state_n = FLAG;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
            mag_valid <= 1'b0;
            mag_bin <= '0;
            mag_data <= '0;
            rd_level <= '0;
            skip_cnt <= '0;
            for (int i = 0; i < NUM_BINS; i++) begin
                snap[i] <= '0;
                level[i] <= '0;
            end
        end else begin
            state <= state_n;
            idx <= idx_n;
            if (capture) snap <= fin;
            mag_valid <= state == SCAN;
            if (state == SCAN) begin
                mag_bin <= idx;
                mag_data <= mag;
            end
            if (mag_valid) level[mag_bin] <= new_lvl > held ? new_lvl : held;
            rd_level <= level[rd_addr];
            if (clr_skip) skip_cnt <= '0;
            else if (done && !capture && skip_cnt != 8'hFF) skip_cnt <= skip_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_fft_bar_reader.sv
// tb_fft_bar_reader: directed self-checking bench for fft_bar_reader
module tb_fft_bar_reader;
    logic clk = 1'b0;
    logic rst_n, en, done, clr_skip;
    logic [31:0] f [16];
    logic [3:0] rd_addr;
    logic [7:0] rd_level;
    logic mag_valid;
    logic [3:0] mag_bin;
    logic [16:0] mag_data;
    logic busy, frame_valid;
    logic [7:0] skip_cnt;
    int total = 0;
    int bad = 0;
    int fv_count;

    fft_bar_reader dut (
        .clk(clk), .rst_n(rst_n), .en(en), .done(done),
        .f0(f[0]), .f1(f[1]), .f2(f[2]), .f3(f[3]),
        .f4(f[4]), .f5(f[5]), .f6(f[6]), .f7(f[7]),
        .f8(f[8]), .f9(f[9]), .f10(f[10]), .f11(f[11]),
        .f12(f[12]), .f13(f[13]), .f14(f[14]), .f15(f[15]),
        .clr_skip(clr_skip), .rd_addr(rd_addr), .rd_level(rd_level),
        .mag_valid(mag_valid), .mag_bin(mag_bin), .mag_data(mag_data),
        .busy(busy), .frame_valid(frame_valid), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        step();
        chk(tag, 32'(rd_level), 32'(exp));
    endtask

    task automatic do_frame(input string tag);
        done = 1'b1;
        en = 1'b1;
        step();
        done = 1'b0;
        repeat (17) step();
        chk({tag, "_fv18"}, 32'(frame_valid), 32'd1);
        step();
        chk({tag, "_idle19"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; done = 1'b0; clr_skip = 1'b0; rd_addr = '0;
        for (int i = 0; i < 16; i++) f[i] = '0;
        for (int c = 0; c < 4; c++) begin
            done = ~done;
            step();
        end
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_mvalid", 32'(mag_valid), 32'd0);
        chk("rst_mbin", 32'(mag_bin), 32'd0);
        chk("rst_mdata", 32'(mag_data), 32'd0);
        chk("rst_skip", 32'(skip_cnt), 32'd0);
        chk("rst_rdlevel", 32'(rd_level), 32'd0);
        done = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_busy", 32'(busy), 32'd0);
        for (int a = 0; a < 16; a++) read_chk("rst_level", 4'(a), 8'd0);

        // frame 1: bin3 = 0x1000 / -0x1000 -> mag 8192, level 32
        f[3] = 32'h1000_F000;
        done = 1'b1;
        step();
        done = 1'b0;
        chk("f1_busy1", 32'(busy), 32'd1);
        chk("f1_mvalid1", 32'(mag_valid), 32'd0);
        step();
        chk("f1_mvalid2", 32'(mag_valid), 32'd1);
        chk("f1_mbin2", 32'(mag_bin), 32'd0);
        chk("f1_mdata2", 32'(mag_data), 32'd0);
        f[5] = 32'h7FFF_7FFF;
        repeat (3) step();
        chk("f1_mbin5", 32'(mag_bin), 32'd3);
        chk("f1_mdata5", 32'(mag_data), 32'd8192);
        repeat (12) step();
        chk("f1_mvalid17", 32'(mag_valid), 32'd1);
        chk("f1_mbin17", 32'(mag_bin), 32'd15);
        chk("f1_fv17", 32'(frame_valid), 32'd0);
        step();
        chk("f1_fv18", 32'(frame_valid), 32'd1);
        chk("f1_mvalid18", 32'(mag_valid), 32'd0);
        chk("f1_busy18", 32'(busy), 32'd1);
        step();
        chk("f1_busy19", 32'(busy), 32'd0);
        chk("f1_fv19", 32'(frame_valid), 32'd0);
        f[5] = '0;
        read_chk("f1_lvl3", 4'd3, 8'd32);
        read_chk("f1_lvl5", 4'd5, 8'd0);
        read_chk("f1_lvl0", 4'd0, 8'd0);

        // saturation then decay on bin0
        f[3] = '0;
        f[0] = 32'h8000_8000;
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("sat_mdata", 32'(mag_data), 32'd65536);
        chk("sat_mbin", 32'(mag_bin), 32'd0);
        repeat (17) step();
        chk("sat_idle", 32'(busy), 32'd0);
        read_chk("sat_lvl0", 4'd0, 8'd255);
        read_chk("dec_lvl3a", 4'd3, 8'd31);
        f[0] = '0;
        do_frame("dec1");
        read_chk("dec_lvl0a", 4'd0, 8'd254);
        f[0] = 32'h0A00_0000;
        do_frame("dec2");
        read_chk("dec_lvl0b", 4'd0, 8'd253);
        read_chk("dec_lvl3b", 4'd3, 8'd29);
        f[0] = '0;

        // decimation: done every 4 cycles for 40 cycles
        chk("dcm_skip0", 32'(skip_cnt), 32'd0);
        fv_count = 0;
        for (int c = 0; c < 40; c++) begin
            done = (c % 4) == 0;
            if (frame_valid) fv_count++;
            if (c == 1) chk("dcm_busy1", 32'(busy), 32'd1);
            if (c == 20) chk("dcm_busy20", 32'(busy), 32'd0);
            if (c == 21) chk("dcm_busy21", 32'(busy), 32'd1);
            step();
        end
        done = 1'b0;
        chk("dcm_fvcount", 32'(fv_count), 32'd2);
        chk("dcm_skip8", 32'(skip_cnt), 32'd8);
        chk("dcm_busy40", 32'(busy), 32'd0);
        en = 1'b0;
        done = 1'b1;
        clr_skip = 1'b1;
        step();
        clr_skip = 1'b0;
        done = 1'b0;
        chk("clr_prio", 32'(skip_cnt), 32'd0);

        // en low blocks captures
        for (int p = 0; p < 3; p++) begin
            done = 1'b1;
            step();
            done = 1'b0;
            chk("en0_busy", 32'(busy), 32'd0);
            step();
        end
        chk("en0_skip3", 32'(skip_cnt), 32'd3);
        done = 1'b1;
        repeat (260) step();
        done = 1'b0;
        chk("skip_sat", 32'(skip_cnt), 32'd255);
        clr_skip = 1'b1;
        step();
        clr_skip = 1'b0;
        chk("skip_clr", 32'(skip_cnt), 32'd0);

        // en dropped mid-scan still completes
        en = 1'b1;
        done = 1'b1;
        step();
        done = 1'b0;
        en = 1'b0;
        repeat (17) step();
        chk("enmid_fv18", 32'(frame_valid), 32'd1);
        step();
        chk("enmid_busy19", 32'(busy), 32'd0);

        // reset during a scan
        f[7] = 32'h4000_0000;
        en = 1'b1;
        done = 1'b1;
        step();
        done = 1'b0;
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_mvalid", 32'(mag_valid), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        fv_count = 0;
        for (int c = 0; c < 12; c++) begin
            if (frame_valid) fv_count++;
            step();
        end
        chk("rmid_nofv", 32'(fv_count), 32'd0);
        for (int a = 0; a < 16; a++) read_chk("rmid_level", 4'(a), 8'd0);
        do_frame("rnext");
        read_chk("rnext_lvl7", 4'd7, 8'd64);
        read_chk("rnext_lvl0", 4'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
